ahb2apb_bridge_mc: RTL and testbench
====================================

Name: ahb2apb_bridge_mc

Overview:
Parametrised next-generation AHB-to-APB bridge: a single AHB slave port fanned out to NUM_SLAVES APB3 slaves through a uniform address map. Adds support for APB wait states (Pready), slave error propagation (Pslverr mapped to the AHB two-cycle ERROR response) and a Pready watchdog. Back-to-back AHB transfers are supported. Sits between the AHB interconnect and the peripheral APB segment.

Parameters:
NUM_SLAVES, 3, number of APB slaves; width of Pselx (1..16)
ADDR_W, 32, address width
DATA_W, 32, data width (32 or 64)
BASE_ADDR, 32'h8000_0000, base of slave 0
SLAVE_SIZE, 32'h0400_0000, region size per slave; power of two
TIMEOUT, 16, maximum ACCESS cycles with Pready low before forced error; 0 disables the watchdog

Ports:
Hclk  in  1  clock; all logic on the rising edge
Hreset  in  1  synchronous, active-high reset
Htrans  in  2  AHB transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
Hwrite  in  1  AHB direction (1 = write)
Hreadyin  in  1  AHB bus ready
Haddr  in  ADDR_W  AHB address
Hwdata  in  DATA_W  AHB write data (valid in the data phase)
Prdata  in  DATA_W  APB read data
Pready  in  1  APB slave ready
Pslverr  in  1  APB slave error
Pselx  out  NUM_SLAVES  one-hot APB selects
Paddr  out  ADDR_W  APB address
Pwdata  out  DATA_W  APB write data
Pwrite  out  1  APB direction
Penable  out  1  APB access phase
Hreadyout  out  1  AHB ready to master
Hresp  out  2  OKAY=00, ERROR=01
Hrdata  out  DATA_W  AHB read data

Behaviour:
- Reset (Hreset high at a clock edge):
  - state IDLE, watchdog counter cleared.
  - Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hrdata=0.
  - Hreadyout=1, Hresp=OKAY.
  - Reset mid-transfer aborts the transfer immediately; no APB completion.
- Accept condition: Hreadyin && Hreadyout && Htrans[1].
  - Haddr, Hwrite and the slave index are latched.
  - Slave index = (Haddr - BASE_ADDR) / SLAVE_SIZE.
  - Address is in-map iff BASE_ADDR <= Haddr < BASE_ADDR + NUM_SLAVES*SLAVE_SIZE.
- IDLE/BUSY transfers: zero-wait OKAY, no APB activity.
- States: IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2.
- Transitions:
  - IDLE, on accept: in-map write -> WWAIT; in-map read -> SETUP; out-of-map -> ERR1.
  - WWAIT: capture Hwdata into Pwdata -> SETUP. Hreadyout=0.
  - SETUP: Pselx one-hot, Penable=0, Paddr/Pwrite valid -> ACCESS. Hreadyout=0.
  - ACCESS: Pselx held, Penable=1. Paddr, Pwrite, Pwdata and Pselx stay stable until completion.
    - Pready=0: stay in ACCESS, Hreadyout=0, watchdog counter increments.
    - Pready=1 && !Pslverr: Hreadyout=1, Hresp=OKAY; Hrdata=Prdata combinationally for reads. Then go to IDLE, or take a new accept in the same cycle (back-to-back) and go to WWAIT/SETUP/ERR1.
    - Pready=1 && Pslverr, or watchdog count == TIMEOUT-1 with TIMEOUT != 0: -> ERR1.
  - ERR1: Hreadyout=0, Hresp=ERROR, Pselx=0, Penable=0 -> ERR2.
  - ERR2: Hreadyout=1, Hresp=ERROR. A new accept in this cycle is honoured as in IDLE.
- Latency from the accept cycle T:
  - read: Penable && Hreadyout at T+2.
  - write: Penable && Hreadyout at T+3.
  - Each Pready=0 cycle adds one cycle.
- Invariants:
  - Pselx is $onehot0 at all times.
  - Penable is never high without Pselx.
  - Penable is never high in two consecutive cycles of the same transfer when Pready=1.
- Watchdog counter clears on every SETUP entry.

Test Plan:
- Read at Haddr=32'h8400_0010, Prdata=32'hCAFE_F00D, Pready=1 -> Pselx=3'b010 at T+1, Penable at T+2, Hrdata=32'hCAFE_F00D with Hreadyout=1 and Hresp=00 at T+2.
- Write at Haddr=32'h8800_0004, Hwdata=32'h1234_5678 -> Pselx=3'b100, Pwrite=1, Pwdata=32'h1234_5678 at T+2, Penable=1 and Hreadyout=1 at T+3.
- Read with Pready low for 3 ACCESS cycles -> Hreadyout=0 for cycles T+1..T+4; completion at T+5; Paddr stable throughout.
- Write where the slave returns Pslverr=1 with Pready=1 -> Hresp=01 with Hreadyout=0, then Hresp=01 with Hreadyout=1 on the next cycle; Pselx=0 in both cycles.
- Read at Haddr=32'h8C00_0000 (out of map) -> Pselx stays 0, two-cycle ERROR; with TIMEOUT=4 and Pready stuck at 0, ERR1 is entered after the 4th ACCESS cycle.
- Write immediately followed by a read accepted on the write-completion cycle, then Hreset asserted during the read's SETUP -> read's Paddr equals the address of the second transfer; after reset all outputs are at reset values and Hreadyout=1.

Source files
------------

// File: rtl/ahb2apb_bridge_mc_if.sv
// AHB slave port plus APB3 master port of the bridge, bundled as one interface.
// "slave" is the bridge view; "master" is the view of whatever drives the AHB side and models the APB slaves.
interface ahb2apb_bridge_mc_if #(
  parameter int NUM_SLAVES = 3,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32
);
  logic [1:0]            Htrans;
  logic                  Hwrite;
  logic                  Hreadyin;
  logic [ADDR_W-1:0]     Haddr;
  logic [DATA_W-1:0]     Hwdata;
  logic [DATA_W-1:0]     Prdata;
  logic                  Pready;
  logic                  Pslverr;
  logic [NUM_SLAVES-1:0] Pselx;
  logic [ADDR_W-1:0]     Paddr;
  logic [DATA_W-1:0]     Pwdata;
  logic                  Pwrite;
  logic                  Penable;
  logic                  Hreadyout;
  logic [1:0]            Hresp;
  logic [DATA_W-1:0]     Hrdata;

  modport slave (
    input  Htrans, Hwrite, Hreadyin, Haddr, Hwdata, Prdata, Pready, Pslverr,
    output Pselx, Paddr, Pwdata, Pwrite, Penable, Hreadyout, Hresp, Hrdata
  );

  modport master (
    output Htrans, Hwrite, Hreadyin, Haddr, Hwdata, Prdata, Pready, Pslverr,
    input  Pselx, Paddr, Pwdata, Pwrite, Penable, Hreadyout, Hresp, Hrdata
  );
endinterface

// File: rtl/ahb2apb_bridge_mc.sv
// AHB-to-APB3 bridge fanning one AHB slave port out to NUM_SLAVES peripherals over a uniform address map.
// Read completes at T+2, write at T+3 (+1 per Pready-low cycle); Pslverr, out-of-map and watchdog give a 2-cycle ERROR.
module ahb2apb_bridge_mc #(
  parameter int                NUM_SLAVES = 3,
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] SLAVE_SIZE = 32'h0400_0000,
  parameter int                TIMEOUT    = 16
) (
  input logic                    Hclk,
  input logic                    Hreset,
  ahb2apb_bridge_mc_if.slave     bus
);

  localparam int          SHIFT   = $clog2(SLAVE_SIZE);
  localparam int          IDX_W   = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int          WD_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [63:0] MAP_LO  = 64'(BASE_ADDR);
  localparam logic [63:0] MAP_HI  = MAP_LO + 64'(NUM_SLAVES) * 64'(SLAVE_SIZE);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [1:0]  RESP_OKAY  = 2'b00;
  localparam logic [1:0]  RESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    IDLE, WWAIT, SETUP, ACCESS, ERR1, ERR2
  } state_t;

  state_t                state_q;
  logic [NUM_SLAVES-1:0] sel_q;
  logic [NUM_SLAVES-1:0] Pselx_q;
  logic [ADDR_W-1:0]     Paddr_q;
  logic [DATA_W-1:0]     Pwdata_q;
  logic                  Pwrite_q;
  logic                  Penable_q;
  logic                  hready_q;
  logic [1:0]            Hresp_q;
  logic [WD_W-1:0]       wd_q;

  logic [63:0]           off;
  logic [IDX_W-1:0]      slave_idx;
  logic [NUM_SLAVES-1:0] dec_sel;
  logic                  in_map;
  logic                  hreadyout;
  logic                  accept;
  logic                  apb_ok;
  logic                  apb_err;
  logic                  wd_fire;

  assign off       = 64'(bus.Haddr) - MAP_LO;
  assign in_map    = (64'(bus.Haddr) >= MAP_LO) && (64'(bus.Haddr) < MAP_HI);
  assign slave_idx = IDX_W'(off >> SHIFT);
  assign dec_sel   = NUM_SLAVES'(1) << slave_idx;

  assign apb_ok    = (state_q == ACCESS) && bus.Pready && !bus.Pslverr;
  assign apb_err   = (state_q == ACCESS) && bus.Pready && bus.Pslverr;
  assign wd_fire   = (TIMEOUT != 0) && (state_q == ACCESS) && !bus.Pready && (wd_q == WD_LAST);

  // Ready goes high combinationally on the APB completion cycle so the next transfer can overlap it.
  assign hreadyout = (state_q == ACCESS) ? apb_ok : hready_q;
  assign accept    = bus.Hreadyin && hreadyout && (bus.Htrans inside {2'b10, 2'b11});

  always_ff @(posedge Hclk) begin
    if (Hreset) begin
      state_q   <= IDLE;
      sel_q     <= '0;
      Pselx_q   <= '0;
      Paddr_q   <= '0;
      Pwdata_q  <= '0;
      Pwrite_q  <= 1'b0;
      Penable_q <= 1'b0;
      hready_q  <= 1'b1;
      Hresp_q   <= RESP_OKAY;
      wd_q      <= '0;
    end else if (accept) begin
      Paddr_q   <= bus.Haddr;
      Pwrite_q  <= bus.Hwrite;
      sel_q     <= dec_sel;
      Pselx_q   <= '0;
      Penable_q <= 1'b0;
      hready_q  <= 1'b0;
      Hresp_q   <= RESP_OKAY;
      if (!in_map) begin
        state_q <= ERR1;
        Hresp_q <= RESP_ERROR;
      end else if (bus.Hwrite) begin
        state_q <= WWAIT;
      end else begin
        state_q <= SETUP;
        Pselx_q <= dec_sel;
        wd_q    <= '0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          hready_q <= 1'b1;
          Hresp_q  <= RESP_OKAY;
        end
        WWAIT: begin
          Pwdata_q <= bus.Hwdata;
          Pselx_q  <= sel_q;
          wd_q     <= '0;
          state_q  <= SETUP;
        end
        SETUP: begin
          Penable_q <= 1'b1;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (apb_ok) begin
            Pselx_q   <= '0;
            Penable_q <= 1'b0;
            hready_q  <= 1'b1;
            state_q   <= IDLE;
          end else if (apb_err || wd_fire) begin
            Pselx_q   <= '0;
            Penable_q <= 1'b0;
            hready_q  <= 1'b0;
            Hresp_q   <= RESP_ERROR;
            state_q   <= ERR1;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
        end
        ERR1: begin
          hready_q <= 1'b1;
          state_q  <= ERR2;
        end
        ERR2: begin
          hready_q <= 1'b1;
          Hresp_q  <= RESP_OKAY;
          state_q  <= IDLE;
        end
        default: begin
          hready_q <= 1'b1;
          Hresp_q  <= RESP_OKAY;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign bus.Pselx     = Pselx_q;
  assign bus.Paddr     = Paddr_q;
  assign bus.Pwdata    = Pwdata_q;
  assign bus.Pwrite    = Pwrite_q;
  assign bus.Penable   = Penable_q;
  assign bus.Hreadyout = hreadyout;
  assign bus.Hresp     = Hresp_q;
  assign bus.Hrdata    = ((state_q == ACCESS) && !Pwrite_q) ? bus.Prdata : '0;

endmodule

// File: tb/tb_ahb2apb_bridge_mc.sv
// Directed bench for ahb2apb_bridge_mc: a scoreboard queue holds the expected APB/AHB result of each transfer.
// Bus invariants are checked every cycle alongside the directed steps.
module tb_ahb2apb_bridge_mc;

  typedef struct {
    logic [31:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [2:0]  psel;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  logic Hclk;
  logic Hreset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   acc_cyc = 0;
  int   rd_acc  = 0;
  bit   mon_en  = 0;
  bit   pen_prev = 0;
  bit   rdy_prev = 0;
  exp_t exp_q[$];

  ahb2apb_bridge_mc_if #(.NUM_SLAVES(3), .ADDR_W(32), .DATA_W(32)) bus ();

  ahb2apb_bridge_mc #(
    .NUM_SLAVES(3), .ADDR_W(32), .DATA_W(32),
    .BASE_ADDR(32'h8000_0000), .SLAVE_SIZE(32'h0400_0000), .TIMEOUT(4)
  ) dut (
    .Hclk   (Hclk),
    .Hreset (Hreset),
    .bus    (bus.slave)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic next();
    @(posedge Hclk);
    #1;
    cyc++;
  endtask

  // Drive one address phase, confirm it is accepted, queue its expected outcome.
  task automatic issue(input logic [31:0] a, input logic w, input exp_t e);
    bus.Htrans = 2'b10;
    bus.Haddr  = a;
    bus.Hwrite = w;
    @(negedge Hclk);
    chk("accept_ready", bus.Hreadyout, 1'b1);
    exp_q.push_back(e);
    acc_cyc = cyc;
    next();
    bus.Htrans = 2'b00;
  endtask

  task automatic run_to_done(input string tag, input int exp_lat);
    exp_t e;
    bit   done;
    done = 0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge Hclk);
      if ((bus.Penable && bus.Hreadyout) || (bus.Hresp == 2'b01 && !bus.Hreadyout)) done = 1;
      else next();
    end
    chk({tag, "_done"}, done, 1'b1);
    chk({tag, "_qsize"}, (exp_q.size() > 0), 1'b1);
    if (done && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_lat"}, cyc - acc_cyc, exp_lat);
      chk({tag, "_paddr"}, bus.Paddr, e.paddr);
      chk({tag, "_pwrite"}, bus.Pwrite, e.pwrite);
      chk({tag, "_psel"}, bus.Pselx, e.psel);
      chk({tag, "_hresp"}, bus.Hresp, e.resp);
      chk({tag, "_hrdata"}, bus.Hrdata, e.rdata);
      if (e.pwrite) chk({tag, "_pwdata"}, bus.Pwdata, e.pwdata);
    end
    next();
  endtask

  always @(negedge Hclk) begin
    if (mon_en) begin
      chk("inv_onehot0", $onehot0(bus.Pselx), 1'b1);
      chk("inv_pen_sel", bus.Penable && (bus.Pselx == 3'b000), 1'b0);
      chk("inv_pen_twice", pen_prev && rdy_prev && bus.Penable, 1'b0);
      pen_prev = bus.Penable;
      rdy_prev = bus.Pready;
    end
  end

  initial begin
    exp_t e;
    bus.Htrans = 2'b00; bus.Hwrite = 1'b0; bus.Hreadyin = 1'b1;
    bus.Haddr = '0; bus.Hwdata = '0; bus.Prdata = '0;
    bus.Pready = 1'b1; bus.Pslverr = 1'b0;
    Hreset = 1'b1;
    repeat (2) @(posedge Hclk);
    #1;
    Hreset = 1'b0;
    @(negedge Hclk);
    chk("rst_pselx", bus.Pselx, 3'b000);
    chk("rst_penable", bus.Penable, 1'b0);
    chk("rst_paddr", bus.Paddr, 32'h0);
    chk("rst_pwdata", bus.Pwdata, 32'h0);
    chk("rst_hrdata", bus.Hrdata, 32'h0);
    chk("rst_hready", bus.Hreadyout, 1'b1);
    chk("rst_hresp", bus.Hresp, 2'b00);
    mon_en = 1;
    next();

    // BUSY transfer: zero-wait OKAY, no APB activity
    bus.Htrans = 2'b01; bus.Haddr = 32'h8000_0000;
    @(negedge Hclk);
    chk("busy_ready", bus.Hreadyout, 1'b1);
    chk("busy_resp", bus.Hresp, 2'b00);
    next();
    bus.Htrans = 2'b00;
    @(negedge Hclk);
    chk("busy_nosel", bus.Pselx, 3'b000);
    next();

    // Simple read to slave 1
    bus.Prdata = 32'hCAFE_F00D;
    e = '{paddr: 32'h8400_0010, pwrite: 1'b0, pwdata: 32'h0, psel: 3'b010, rdata: 32'hCAFE_F00D, resp: 2'b00};
    issue(32'h8400_0010, 1'b0, e);
    @(negedge Hclk);
    chk("rd_setup_sel", bus.Pselx, 3'b010);
    chk("rd_setup_pen", bus.Penable, 1'b0);
    chk("rd_setup_rdy", bus.Hreadyout, 1'b0);
    next();
    run_to_done("rd", 2);

    // Simple write to slave 2
    e = '{paddr: 32'h8800_0004, pwrite: 1'b1, pwdata: 32'h1234_5678, psel: 3'b100, rdata: 32'h0, resp: 2'b00};
    issue(32'h8800_0004, 1'b1, e);
    bus.Hwdata = 32'h1234_5678;
    next();
    @(negedge Hclk);
    chk("wr_setup_sel", bus.Pselx, 3'b100);
    chk("wr_setup_pwrite", bus.Pwrite, 1'b1);
    chk("wr_setup_pwdata", bus.Pwdata, 32'h1234_5678);
    chk("wr_setup_pen", bus.Penable, 1'b0);
    next();
    run_to_done("wr", 3);

    // Read with three Pready-low ACCESS cycles
    bus.Pready = 1'b0;
    bus.Prdata = 32'h5A5A_0001;
    e = '{paddr: 32'h8000_0020, pwrite: 1'b0, pwdata: 32'h0, psel: 3'b001, rdata: 32'h5A5A_0001, resp: 2'b00};
    issue(32'h8000_0020, 1'b0, e);
    for (int i = 1; i <= 4; i++) begin
      @(negedge Hclk);
      chk("ws_rdy_low", bus.Hreadyout, 1'b0);
      chk("ws_paddr", bus.Paddr, 32'h8000_0020);
      if (i >= 2) chk("ws_pen", bus.Penable, 1'b1);
      next();
    end
    bus.Pready = 1'b1;
    run_to_done("ws", 5);

    // Write answered with Pslverr
    e = '{paddr: 32'h8000_0100, pwrite: 1'b1, pwdata: 32'hDEAD_BEEF, psel: 3'b000, rdata: 32'h0, resp: 2'b01};
    issue(32'h8000_0100, 1'b1, e);
    bus.Hwdata  = 32'hDEAD_BEEF;
    bus.Pslverr = 1'b1;
    run_to_done("slverr", 4);
    @(negedge Hclk);
    chk("slverr_err2_resp", bus.Hresp, 2'b01);
    chk("slverr_err2_rdy", bus.Hreadyout, 1'b1);
    chk("slverr_err2_sel", bus.Pselx, 3'b000);
    bus.Pslverr = 1'b0;
    next();

    // Out-of-map read
    e = '{paddr: 32'h8C00_0000, pwrite: 1'b0, pwdata: 32'h0, psel: 3'b000, rdata: 32'h0, resp: 2'b01};
    issue(32'h8C00_0000, 1'b0, e);
    run_to_done("oom", 1);
    @(negedge Hclk);
    chk("oom_err2_resp", bus.Hresp, 2'b01);
    chk("oom_err2_rdy", bus.Hreadyout, 1'b1);
    chk("oom_err2_sel", bus.Pselx, 3'b000);
    next();

    // Watchdog with Pready stuck low
    bus.Pready = 1'b0;
    e = '{paddr: 32'h8000_0040, pwrite: 1'b0, pwdata: 32'h0, psel: 3'b000, rdata: 32'h0, resp: 2'b01};
    issue(32'h8000_0040, 1'b0, e);
    run_to_done("wdog", 6);
    @(negedge Hclk);
    chk("wdog_err2_resp", bus.Hresp, 2'b01);
    chk("wdog_err2_rdy", bus.Hreadyout, 1'b1);
    bus.Pready = 1'b1;
    next();

    // Back-to-back write then read, reset during the read's SETUP
    e = '{paddr: 32'h8000_0008, pwrite: 1'b1, pwdata: 32'hA5A5_0006, psel: 3'b001, rdata: 32'h0, resp: 2'b00};
    issue(32'h8000_0008, 1'b1, e);
    bus.Hwdata = 32'hA5A5_0006;
    next();
    next();
    bus.Htrans = 2'b10; bus.Haddr = 32'h8400_0044; bus.Hwrite = 1'b0;
    e = '{paddr: 32'h8400_0044, pwrite: 1'b0, pwdata: 32'h0, psel: 3'b010, rdata: 32'h0, resp: 2'b00};
    exp_q.push_back(e);
    rd_acc = cyc;
    run_to_done("b2b_wr", 3);
    bus.Htrans = 2'b00;
    @(negedge Hclk);
    chk("b2b_rd_lat", cyc - rd_acc, 1);
    chk("b2b_rd_paddr", bus.Paddr, 32'h8400_0044);
    chk("b2b_rd_sel", bus.Pselx, 3'b010);
    chk("b2b_rd_pwrite", bus.Pwrite, 1'b0);
    Hreset = 1'b1;
    next();
    @(negedge Hclk);
    chk("mrst_pselx", bus.Pselx, 3'b000);
    chk("mrst_penable", bus.Penable, 1'b0);
    chk("mrst_pwrite", bus.Pwrite, 1'b0);
    chk("mrst_paddr", bus.Paddr, 32'h0);
    chk("mrst_pwdata", bus.Pwdata, 32'h0);
    chk("mrst_hrdata", bus.Hrdata, 32'h0);
    chk("mrst_hready", bus.Hreadyout, 1'b1);
    chk("mrst_hresp", bus.Hresp, 2'b00);
    Hreset = 1'b0;
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    next();
    next();
    @(negedge Hclk);
    chk("post_rst_pen", bus.Penable, 1'b0);
    chk("post_rst_sel", bus.Pselx, 3'b000);
    chk("sb_empty", exp_q.size(), 0);
    mon_en = 0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
